uart_tx_feeder: RTL

- Byte-queue and pacing stage directly upstream of the UART transmitter.
- Accepts words from the system over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Presents each word to the transmitter's parallel `data` input with a one-cycle `up_data` load pulse.
- Spaces load pulses by exactly one serial frame, so a frame in flight is never overwritten.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync_fifo.sv | 61 ++++++
 rtl/uart_tx_feeder.sv | 101 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and frame-length helper for the UART TX feeder
package uart_pkg;

   localparam int N_DEFAULT = 8;

   typedef enum logic {
      IDLE = 1'b0,
      GAP  = 1'b1
   } feeder_state_t;

   // start + N data + parity + stop
   function automatic int frame_len(input int n);
      return n + 3;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous circular-buffer FIFO shared by the UART TX and RX paths
module uart_sync_fifo #(
   parameter  int N     = 8,
   parameter  int DEPTH = 8,
   localparam int PW    = $clog2(DEPTH),
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [N-1:0]  wdata,
   output logic [N-1:0]  rdata,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);

   logic [N-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          w_push;
   logic          w_pop;

   // full is taken from the registered level, so a same-cycle pop never frees a slot
   assign w_push = rst_n & push & ~full;
   assign w_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign rdata = r_mem[r_rd_ptr];
   assign level = r_level;
   assign full  = (r_level == LW'(DEPTH));
   assign empty = (r_level == '0);

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - queues words and issues them to the UART transmitter one frame apart
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter  int N         = N_DEFAULT,
   parameter  int DEPTH     = 8,
   parameter  int FRAME_LEN = frame_len(N),
   localparam int LW        = $clog2(DEPTH + 1),
   localparam int GW        = $clog2(FRAME_LEN)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [N-1:0]  data,
   output logic          up_data,
   output logic          busy,
   output logic [LW-1:0] level
);

   feeder_state_t r_state;
   feeder_state_t w_state_nxt;
   logic [GW-1:0] r_gap_cnt;
   logic [GW-1:0] w_gap_nxt;
   logic [N-1:0]  r_data;
   logic [N-1:0]  w_data_nxt;
   logic          r_up_data;
   logic          w_up_nxt;
   logic          w_pop;
   logic          w_push;
   logic [N-1:0]  w_rdata;
   logic [LW-1:0] w_level;
   logic          w_full;
   logic          w_empty;

   assign in_ready = rst_n & ~w_full;
   assign w_push   = in_valid & in_ready;

   uart_sync_fifo #(
      .N     (N),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .wdata (in_data),
      .rdata (w_rdata),
      .level (w_level),
      .full  (w_full),
      .empty (w_empty)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap_cnt;
      w_data_nxt  = r_data;
      w_up_nxt    = 1'b0;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_data_nxt  = w_rdata;
               w_up_nxt    = 1'b1;
               w_gap_nxt   = GW'(FRAME_LEN - 1);
               w_state_nxt = GAP;
            end
         end
         GAP: begin
            // leaving at count 1 lets the next pop land exactly FRAME_LEN edges after the last
            w_gap_nxt = r_gap_cnt - GW'(1);
            if (r_gap_cnt == GW'(1)) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_gap_cnt <= '0;
         r_data    <= '0;
         r_up_data <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_gap_cnt <= w_gap_nxt;
         r_data    <= w_data_nxt;
         r_up_data <= w_up_nxt;
      end
   end

   assign data    = r_data;
   assign up_data = r_up_data;
   assign level   = w_level;
   assign busy    = (w_level != '0) | (r_state == GAP);

endmodule
